// File: rtl/ysyx_23060236_rd_arbiter_pkg.sv
// Shared definitions for the AXI-lite read-channel arbiter: FSM state
// encodings and master index constants.
package ysyx_23060236_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic ARB_M_IFU = 1'b0;
  localparam logic ARB_M_LSU = 1'b1;

  // Master 0 wins the first tie under round-robin, so the reset value of
  // the "most recently completed owner" points at master 1.
  localparam logic ARB_LAST_RESET = ARB_M_LSU;

endpackage

// File: rtl/ysyx_23060236_rd_arbiter_pick.sv
// Combinational 2-way request picker.
// Tie-break policy: YSYX_23060236_ARB_RR_EN defined -> round-robin against
// the last completed owner; undefined -> master 1 (LSU) always wins ties.
import ysyx_23060236_rd_arbiter_pkg::*;

module ysyx_23060236_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel
);

`ifndef YSYX_23060236_ARB_RR_EN
  // Fixed priority does not consult the history bit.
  logic unused_last_s;
  assign unused_last_s = last;
`endif

  // Single request picks that master; a tie is resolved by the policy.
  always_comb begin
    sel = ARB_M_IFU;
    case (req)
      2'b01:   sel = ARB_M_IFU;
      2'b10:   sel = ARB_M_LSU;
`ifdef YSYX_23060236_ARB_RR_EN
      2'b11:   sel = ~last;
`else
      2'b11:   sel = ARB_M_LSU;
`endif
      default: sel = ARB_M_IFU;
    endcase
  end

endmodule

// File: rtl/ysyx_23060236_rd_arbiter_reg.sv
// Generic write-enabled register with synchronous active-high reset.
module ysyx_23060236_Reg #(
  parameter int unsigned              WIDTH     = 1,
  parameter logic [WIDTH-1:0]         RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  // Hold value, load on write enable, return to RESET_VAL on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end else begin
      dout <= dout;
    end
  end

endmodule

// File: rtl/ysyx_23060236_rd_arbiter.sv
// Two-master / one-slave AXI-lite read arbiter (AR/R only). One whole read
// transaction is granted at a time and the response is routed back to the
// owner. Tie-break policy selected by YSYX_23060236_ARB_RR_EN.
import ysyx_23060236_rd_arbiter_pkg::*;

module ysyx_23060236_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready
);

  logic [1:0]        state_bits_r;
  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic              owner_r;
  logic              owner_nxt_s;
  logic              owner_wen_s;
  logic              last_r;
  logic              last_nxt_s;
  logic              last_wen_s;
  logic [1:0]        req_s;
  logic              pick_sel_s;
  logic              own_arvalid_s;
  logic              own_rready_s;
  logic [ADDR_W-1:0] own_araddr_s;

  assign state_r       = arb_state_e'(state_bits_r);
  assign req_s         = {m1_arvalid, m0_arvalid};
  assign own_arvalid_s = (owner_r == ARB_M_LSU) ? m1_arvalid : m0_arvalid;
  assign own_rready_s  = (owner_r == ARB_M_LSU) ? m1_rready  : m0_rready;
  assign own_araddr_s  = (owner_r == ARB_M_LSU) ? m1_araddr  : m0_araddr;

  ysyx_23060236_arb_pick u_pick (
    .req  (req_s),
    .last (last_r),
    .sel  (pick_sel_s)
  );

  ysyx_23060236_Reg #(.WIDTH(2), .RESET_VAL(ARB_IDLE)) u_state_reg (
    .clock (clock), .reset (reset), .din (state_nxt_s), .wen (1'b1), .dout (state_bits_r)
  );

  ysyx_23060236_Reg #(.WIDTH(1), .RESET_VAL(ARB_M_IFU)) u_owner_reg (
    .clock (clock), .reset (reset), .din (owner_nxt_s), .wen (owner_wen_s), .dout (owner_r)
  );

  ysyx_23060236_Reg #(.WIDTH(1), .RESET_VAL(ARB_LAST_RESET)) u_last_reg (
    .clock (clock), .reset (reset), .din (last_nxt_s), .wen (last_wen_s), .dout (last_r)
  );

  // Next state: grant in IDLE, wait for AR handshake (or abandoned request)
  // in ADDR, wait for R handshake in DATA and record the finished owner.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    owner_wen_s = 1'b0;
    last_nxt_s  = last_r;
    last_wen_s  = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (|req_s) begin
          state_nxt_s = ARB_ADDR;
          owner_nxt_s = pick_sel_s;
          owner_wen_s = 1'b1;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_ADDR: begin
        if (own_arvalid_s && s_arready) begin
          state_nxt_s = ARB_DATA;
        end else if (!own_arvalid_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_ADDR;
        end
      end
      ARB_DATA: begin
        if (s_rvalid && own_rready_s) begin
          state_nxt_s = ARB_IDLE;
          last_nxt_s  = owner_r;
          last_wen_s  = 1'b1;
        end else begin
          state_nxt_s = ARB_DATA;
        end
      end
      default: state_nxt_s = ARB_IDLE;
    endcase
  end

  // Handshake routing: only the owner ever sees arready/rvalid, and the
  // slave only sees the owner's request/ready in the matching phase.
  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_araddr   = {ADDR_W{1'b0}};
    case (state_r)
      ARB_ADDR: begin
        s_araddr  = own_araddr_s;
        s_arvalid = own_arvalid_s;
        if (owner_r == ARB_M_LSU) begin
          m1_arready = s_arready;
        end else begin
          m0_arready = s_arready;
        end
      end
      ARB_DATA: begin
        s_rready = own_rready_s;
        if (owner_r == ARB_M_LSU) begin
          m1_rvalid = s_rvalid;
        end else begin
          m0_rvalid = s_rvalid;
        end
      end
      default: s_arvalid = 1'b0;
    endcase
  end

  // Response payload is broadcast; rvalid alone qualifies it.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// Self-checking bench for ysyx_23060236_rd_arbiter: directed scenarios then
// randomized traffic, all compared against a transaction-level model.
module tb_ysyx_23060236_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_araddr = 32'h0, m1_araddr = 32'h0, s_rdata = 32'h0;
  logic [31:0] s_araddr, m0_rdata, m1_rdata;
  logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0, m0_rready = 1'b0, m1_rready = 1'b0;
  logic        s_arready = 1'b0, s_rvalid = 1'b0;
  logic [1:0]  s_rresp = 2'b00;
  logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready;
  logic [1:0]  m0_rresp, m1_rresp;

  int n_checks = 0;
  int n_fails  = 0;

  // Transaction-level model: is a transaction open, has its address been
  // accepted, who owns it, and who finished most recently.
  bit md_busy = 1'b0;
  bit md_addr_done = 1'b0;
  int md_own = 0;
  int md_last = 1;
  int dut_grants[$];
  bit hs0, hs1;
  logic [31:0] mtime = 32'h0000_1000;

`ifdef YSYX_23060236_ARB_RR_EN
  localparam int FIRST_TIE = 0;
`else
  localparam int FIRST_TIE = 1;
`endif

  ysyx_23060236_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clock = ~clock;

  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef YSYX_23060236_ARB_RR_EN
    return 1 - last;
`else
    return 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs,
  // then advance the model to the state after the next rising edge.
  task automatic step(input bit rst, input bit a0v, input logic [31:0] a0,
                      input bit a1v, input logic [31:0] a1, input bit r0, input bit r1,
                      input bit sar, input bit srv, input logic [31:0] sd, input logic [1:0] sr);
    bit          av[2];
    bit          rr[2];
    logic [31:0] ad[2];
    logic [1:0]  e_ar, e_rv;
    logic        e_sav, e_srr;
    logic [31:0] e_saddr;
    @(negedge clock);
    reset = rst; m0_arvalid = a0v; m0_araddr = a0; m1_arvalid = a1v; m1_araddr = a1;
    m0_rready = r0; m1_rready = r1; s_arready = sar; s_rvalid = srv; s_rdata = sd; s_rresp = sr;
    av[0] = a0v; av[1] = a1v; rr[0] = r0; rr[1] = r1; ad[0] = a0; ad[1] = a1;
    #1;
    e_ar = 2'b00; e_rv = 2'b00; e_sav = 1'b0; e_srr = 1'b0; e_saddr = 32'h0;
    if (md_busy && !md_addr_done) begin
      e_sav = av[md_own]; e_saddr = ad[md_own]; e_ar[md_own] = sar;
    end else if (md_busy) begin
      e_srr = rr[md_own]; e_rv[md_own] = srv;
    end
    check("m0_arready", {31'h0, m0_arready}, {31'h0, e_ar[0]});
    check("m1_arready", {31'h0, m1_arready}, {31'h0, e_ar[1]});
    check("m0_rvalid",  {31'h0, m0_rvalid},  {31'h0, e_rv[0]});
    check("m1_rvalid",  {31'h0, m1_rvalid},  {31'h0, e_rv[1]});
    check("s_arvalid",  {31'h0, s_arvalid},  {31'h0, e_sav});
    check("s_rready",   {31'h0, s_rready},   {31'h0, e_srr});
    check("s_araddr",   s_araddr, e_saddr);
    check("m0_rdata",   m0_rdata, sd);
    check("m1_rdata",   m1_rdata, sd);
    check("rresp",      {28'h0, m1_rresp, m0_rresp}, {28'h0, sr, sr});
    hs0 = a0v & e_ar[0];
    hs1 = a1v & e_ar[1];
    if (m0_arvalid && m0_arready) dut_grants.push_back(0);
    if (m1_arvalid && m1_arready) dut_grants.push_back(1);
    if (rst) begin
      md_busy = 1'b0; md_addr_done = 1'b0; md_own = 0; md_last = 1;
    end else if (!md_busy) begin
      if (a0v || a1v) begin
        md_busy = 1'b1; md_addr_done = 1'b0; md_own = pick(a0v, a1v, md_last);
      end
    end else if (!md_addr_done) begin
      if (av[md_own] && sar) md_addr_done = 1'b1;
      else if (!av[md_own]) md_busy = 1'b0;
    end else if (srv && rr[md_own]) begin
      md_busy = 1'b0; md_addr_done = 1'b0; md_last = md_own;
    end
  endtask

  task automatic do_reset();
    step(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 2'b00);
    step(1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 2'b00);
  endtask

  initial begin
    bit          req[2];
    logic [31:0] addr[2];
    int          exp_seq[6];

    // Reset state: everything idle.
    do_reset();
    step(0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 1, 32'hdead_beef, 2'b00);

    // Single m0 read of mtime low: IDLE, ADDR, DATA; m1 never sees anything.
    dut_grants.delete();
    step(0, 1, 32'ha000_0048, 0, 32'h0, 1, 1, 1, 0, mtime, 2'b00);
    check("t1_idle_no_arvalid", {31'h0, s_arvalid}, 32'h0);
    step(0, 1, 32'ha000_0048, 0, 32'h0, 1, 1, 1, 0, mtime, 2'b00);
    check("t1_arvalid_next", {31'h0, s_arvalid}, 32'h1);
    step(0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 1, mtime, 2'b00);
    check("t1_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    check("t1_m0_rdata", m0_rdata, 32'h0000_1000);
    step(0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 1, mtime, 2'b00);
    check("t1_grants", dut_grants.size(), 1);
    if (dut_grants.size() > 0) check("t1_owner", dut_grants[0], 0);

    // Both masters requesting continuously for six transactions.
    do_reset();
    dut_grants.delete();
    for (int i = 0; i < 18; i++)
      step(0, 1, 32'h0000_1000 + i, 1, 32'h0000_2000 + i, 1, 1, 1, 1, 32'h100 + i, 2'b00);
`ifdef YSYX_23060236_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
    check("t2_grant_count", dut_grants.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < dut_grants.size()) check("t2_grant_seq", dut_grants[i], exp_seq[i]);

    // Wait states: slave arready low 4 cycles, m0 rready low 3 cycles.
    do_reset();
    dut_grants.delete();
    step(0, 1, 32'ha000_004c, 0, 32'h0, 0, 0, 0, 0, 32'h0, 2'b00);
    for (int i = 0; i < 4; i++)
      step(0, 1, 32'ha000_004c, 1, 32'h0000_0040, 0, 1, 0, 0, 32'h0, 2'b00);
    step(0, 1, 32'ha000_004c, 1, 32'h0000_0040, 0, 1, 1, 0, 32'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h0, 1, 32'h0000_0040, 0, 1, 1, 1, 32'h5a5a_0001, 2'b01);
      check("t3_rdata_held", m0_rdata, 32'h5a5a_0001);
      check("t3_m1_no_rvalid", {31'h0, m1_rvalid}, 32'h0);
    end
    step(0, 0, 32'h0, 1, 32'h0000_0040, 1, 1, 1, 1, 32'h5a5a_0001, 2'b01);
    check("t3_grants", dut_grants.size(), 1);
    if (dut_grants.size() > 0) check("t3_owner", dut_grants[0], 0);
    step(0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 2'b00);
    step(0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 2'b00);

    // Reset pulsed in DATA with rvalid pending; next tie uses reset history.
    step(0, 1, 32'ha000_0048, 0, 32'h0, 0, 0, 1, 0, 32'h0, 2'b00);
    step(0, 1, 32'ha000_0048, 0, 32'h0, 0, 0, 1, 0, 32'h0, 2'b00);
    step(0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 1, 32'h77, 2'b00);
    step(1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 1, 32'h77, 2'b00);
    dut_grants.delete();
    step(0, 1, 32'h10, 1, 32'h20, 1, 1, 1, 1, 32'h77, 2'b00);
    check("t4_idle_after_reset", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
    step(0, 1, 32'h10, 1, 32'h20, 1, 1, 1, 0, 32'h0, 2'b00);
    check("t4_grants", dut_grants.size(), 1);
    if (dut_grants.size() > 0) check("t4_tie_owner", dut_grants[0], FIRST_TIE);
    step(0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 1, 32'h0, 2'b00);

    // Owner abandons its request in ADDR; the other pending master is next.
    do_reset();
    dut_grants.delete();
    step(0, 1, 32'h30, 1, 32'h40, 1, 1, 0, 0, 32'h0, 2'b00);
    step(0, 1, 32'h30, 1, 32'h40, 1, 1, 0, 0, 32'h0, 2'b00);
    step(0, FIRST_TIE == 1, 32'h30, FIRST_TIE == 0, 32'h40, 1, 1, 0, 0, 32'h0, 2'b00);
    step(0, FIRST_TIE == 1, 32'h30, FIRST_TIE == 0, 32'h40, 1, 1, 0, 0, 32'h0, 2'b00);
    step(0, FIRST_TIE == 1, 32'h30, FIRST_TIE == 0, 32'h40, 1, 1, 1, 0, 32'h0, 2'b00);
    check("t5_grants", dut_grants.size(), 1);
    if (dut_grants.size() > 0) check("t5_other_owner", dut_grants[0], 1 - FIRST_TIE);
    step(0, 0, 32'h0, 0, 32'h0, 1, 1, 1, 1, 32'h99, 2'b00);

    // Randomized traffic with occasional abandoned requests and resets.
    req[0] = 1'b0; req[1] = 1'b0; addr[0] = 32'h0; addr[1] = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m]) begin
          if ($urandom_range(1, 0) == 1) begin req[m] = 1'b1; addr[m] = $urandom; end
        end else if ($urandom_range(19, 0) == 0) begin
          req[m] = 1'b0;
        end
      end
      step($urandom_range(199, 0) == 0, req[0], addr[0], req[1], addr[1],
           $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
           $urandom_range(1, 0) == 1,
           md_busy && md_addr_done && ($urandom_range(2, 0) != 0),
           mtime, 2'($urandom_range(3, 0)));
      if (hs0) req[0] = 1'b0;
      if (hs1) req[1] = 1'b0;
      mtime = mtime + 32'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
